// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default accumulator width, int8 limits
// and the accumulator FSM state encoding.
package cnn_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int Q_MAX     = 127;
   localparam int Q_MIN     = -128;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/conv_accum_quant_if.sv
// Bus bundle for conv_accum_quant: product stream in, int8 result out.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready are both high. A source holds valid and its payload
// stable until that transfer. A source never waits for ready before raising
// valid.
interface conv_accum_quant_if;

   logic        prodValid_in;
   logic        prodLast_in;
   logic [31:0] prodData_in;
   logic        prodReady_out;
   logic [31:0] bias_in;
   logic [4:0]  shift_in;
   logic        resValid_out;
   logic [7:0]  resData_out;
   logic        resReady_in;
   logic        lenErr_out;

   modport master (
      output prodValid_in, prodLast_in, prodData_in, bias_in, shift_in, resReady_in,
      input  prodReady_out, resValid_out, resData_out, lenErr_out
   );

   modport slave (
      input  prodValid_in, prodLast_in, prodData_in, bias_in, shift_in, resReady_in,
      output prodReady_out, resValid_out, resData_out, lenErr_out
   );

endinterface

// File: rtl/acc_requant.sv
// Combinational requantizer: round-to-nearest, arithmetic right shift,
// optional ReLU, saturate to int8.
// Optional feature macro: CONV_ACC_RELU_EN (clamps negative values to 0).
module acc_requant
   import cnn_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] i_sum,
   input  logic [4:0]       i_shift,
   output logic [7:0]       o_q
);

   // One extra bit keeps sum + round term from wrapping.
   localparam logic signed [ACC_W:0] L_MAX = (ACC_W+1)'(Q_MAX);
   localparam logic signed [ACC_W:0] L_MIN = (ACC_W+1)'(Q_MIN);

   logic signed [ACC_W:0] w_ext;
   logic signed [ACC_W:0] w_rnd;
   logic signed [ACC_W:0] w_shr;
   logic signed [ACC_W:0] w_act;

   // Round, shift, optional ReLU, then clamp into the int8 range.
   always_comb begin
      w_ext = signed'({i_sum[ACC_W-1], i_sum});
      w_rnd = '0;
      if (i_shift != 5'd0) begin
         w_rnd = (ACC_W+1)'(1) << (i_shift - 5'd1);
      end
      w_shr = (w_ext + w_rnd) >>> i_shift;
`ifdef CONV_ACC_RELU_EN
      w_act = w_shr[ACC_W] ? '0 : w_shr;
`else
      w_act = w_shr;
`endif
      if (w_act > L_MAX) begin
         o_q = L_MAX[7:0];
      end else if (w_act < L_MIN) begin
         o_q = L_MIN[7:0];
      end else begin
         o_q = w_act[7:0];
      end
   end

endmodule

// File: rtl/conv_accum_quant.sv
// Kernel-window accumulator: sums signed products, adds bias on the last
// beat, requantizes to int8 and holds the result until the consumer takes it.
// A new window may start in the same cycle the held result is consumed.
module conv_accum_quant
   import cnn_pkg::*;
#(
   parameter int KERNEL_LEN = 25,
   parameter int ACC_W      = ACC_W_DEF
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               clear_in,
   conv_accum_quant_if.slave  bus,
   output state_t             o_dbg_state
);

   localparam int CNT_W = $clog2(KERNEL_LEN) + 1;
   localparam logic [CNT_W-1:0] L_LAST_IDX = CNT_W'(KERNEL_LEN - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_res;
   logic             r_err;

   logic             w_ready;
   logic             w_accept;
   logic             w_last;
   logic             w_consume;
   logic [ACC_W-1:0] w_beat;
   logic [ACC_W-1:0] w_sum;
   logic [7:0]       w_q;

   assign w_ready   = (r_state != ST_HOLD) || bus.resReady_in;
   assign w_accept  = bus.prodValid_in && w_ready;
   assign w_last    = w_accept && bus.prodLast_in;
   assign w_consume = (r_state == ST_HOLD) && bus.resReady_in;
   assign w_beat    = ACC_W'(signed'(bus.prodData_in));
   assign w_sum     = r_acc + w_beat + ACC_W'(signed'(bus.bias_in));

   acc_requant #(.ACC_W(ACC_W)) u_requant (
      .i_sum   (w_sum),
      .i_shift (bus.shift_in),
      .o_q     (w_q)
   );

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: clear wins, a new last beat re-enters HOLD even while the
   // previous result is being consumed, otherwise a consume returns to ACCUM.
   always_comb begin
      w_state_nxt = r_state;
      if (clear_in) begin
         w_state_nxt = ST_ACCUM;
      end else if (w_last) begin
         w_state_nxt = ST_HOLD;
      end else if (w_consume) begin
         w_state_nxt = ST_ACCUM;
      end
   end

   // Accumulator, beat counter, held result and sticky length error.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_res <= '0;
         r_err <= 1'b0;
      end else if (clear_in) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (bus.prodLast_in) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= w_q;
            if (r_cnt != L_LAST_IDX) begin
               r_err <= 1'b1;
            end
         end else begin
            r_acc <= r_acc + w_beat;
            // Saturate so an overlong window cannot wrap back to a legal count.
            if (r_cnt != '1) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.prodReady_out = w_ready;
   assign bus.resValid_out  = (r_state == ST_HOLD);
   assign bus.resData_out   = r_res;
   assign bus.lenErr_out    = r_err;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_conv_accum_quant.sv
// Bench for conv_accum_quant with KERNEL_LEN = 3: directed windows, a stalled
// consumer, back-to-back windows, randomized windows, and mid-window abort by
// reset and by clear. Expected results come from an arithmetic model.
module tb_conv_accum_quant;
   import cnn_pkg::*;

   localparam int K = 3;

   logic   clk;
   logic   rst_n;
   logic   clear;
   state_t dbg_state;

   conv_accum_quant_if bus();

   conv_accum_quant #(.KERNEL_LEN(K)) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .clear_in    (clear),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   int checks       = 0;
   int failures     = 0;
   int stall_cycles = 0;
   int n_results    = 0;
   int rdy_mode     = 0;   // 0: ready high, 1: ready low, 2: random
   bit model_err    = 1'b0;
   logic [8:0] exp_q[$];   // {lenErr, resData}

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Consumer ready driver.
   initial begin
      bus.resReady_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.resReady_in = 1'b1;
            1:       bus.resReady_in = 1'b0;
            default: bus.resReady_in = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the whole window.
   function automatic logic [7:0] model_q(input int beats[$], input int bias, input int sh);
      longint s;
      int     s32;
      longint v;
      s = longint'(bias);
      foreach (beats[i]) s += longint'(beats[i]);
      s32 = int'(s);
      v = longint'(s32);
      if (sh > 0) v += longint'(1) << (sh - 1);
      v = v >>> sh;
`ifdef CONV_ACC_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   // Drive one beat and wait until it is accepted (bounded).
   task automatic send_beat(input int d, input bit last, input int bias, input int sh);
      int waited = 0;
      bit ok = 1'b0;
      bus.prodValid_in = 1'b1;
      bus.prodLast_in  = last;
      bus.prodData_in  = d;
      bus.bias_in      = bias;
      bus.shift_in     = 5'(sh);
      while (!ok && waited < 200) begin
         @(negedge clk);
         if (bus.prodReady_out) ok = 1'b1;
         else waited++;
         @(posedge clk);
         #1;
      end
      stall_cycles += waited;
      bus.prodValid_in = 1'b0;
      bus.prodLast_in  = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=not_accepted required=accepted");
      end
   endtask

   task automatic expect_window(input int beats[$], input int bias, input int sh);
      if (beats.size() != K) model_err = 1'b1;
      exp_q.push_back({model_err, model_q(beats, bias, sh)});
   endtask

   // Whole window; bias and shift are garbage except on the last beat.
   task automatic send_window(input int beats[$], input int bias, input int sh, input bit gaps);
      for (int i = 0; i < beats.size(); i++) begin
         bit last;
         last = (i == beats.size() - 1);
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(beats[i], last, last ? bias : int'($urandom),
                   last ? sh : int'($urandom_range(0, 31)));
      end
      expect_window(beats, bias, sh);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   // Monitor: every consumed result is popped and compared.
   always @(negedge clk) begin
      if (rst_n && bus.resValid_out && bus.resReady_in) begin
         logic [8:0] e;
         checks++;
         n_results++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL result_unexpected actual=%0h required=none", bus.resData_out);
         end else begin
            e = exp_q.pop_front();
            if ({bus.lenErr_out, bus.resData_out} !== e) begin
               failures++;
               $display("FAIL result actual=err%0d/%0h required=err%0d/%0h",
                        bus.lenErr_out, bus.resData_out, e[8], e[7:0]);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #2000000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Main stimulus.
   initial begin
      int beats[$];
      int r0;
      logic [7:0] exp_stall;
      rst_n = 1'b0;
      clear = 1'b0;
      bus.prodValid_in = 1'b0;
      bus.prodLast_in  = 1'b0;
      bus.prodData_in  = '0;
      bus.bias_in      = '0;
      bus.shift_in     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.resValid_out, 0);
      check("rst_data", bus.resData_out, 0);
      check("rst_err", bus.lenErr_out, 0);
      check("rst_ready", bus.prodReady_out, 1);
      check("rst_state", dbg_state, ST_ACCUM);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed windows.
      beats = {100, 200, -50};
      send_window(beats, 6, 2, 1'b0);
      @(negedge clk);
      check("lat_valid", bus.resValid_out, 1);
      check("t1_data", bus.resData_out, 8'd64);
      check("t1_err", bus.lenErr_out, 0);
      @(posedge clk);
      #1;
      beats = {40000};
      send_window(beats, 0, 8, 1'b0);
      @(negedge clk);
      check("t2_data", bus.resData_out, 8'd127);
      check("t2_err", bus.lenErr_out, 1);
      @(posedge clk);
      #1;
      beats = {-1000};
      send_window(beats, 0, 2, 1'b0);
      @(negedge clk);
`ifdef CONV_ACC_RELU_EN
      check("t3_data", bus.resData_out, 8'h00);
`else
      check("t3_data", bus.resData_out, 8'h80);
`endif
      @(posedge clk);
      #1;
      drain();
      pulse_clear();
      model_err = 1'b0;
      @(negedge clk);
      check("clear_err", bus.lenErr_out, 0);
      @(posedge clk);
      #1;

      // Stalled consumer.
      rdy_mode = 1;
      @(posedge clk);
      #2;
      beats = {11, -7, 300};
      exp_stall = model_q(beats, -100, 1);
      send_window(beats, -100, 1, 1'b0);
      bus.prodValid_in = 1'b1;
      bus.prodLast_in  = 1'b0;
      bus.prodData_in  = 5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", bus.resValid_out, 1);
         check("stall_data", bus.resData_out, exp_stall);
         check("stall_ready", bus.prodReady_out, 0);
         check("stall_state", dbg_state, ST_HOLD);
      end
      rdy_mode = 0;
      @(posedge clk);
      #2;
      @(negedge clk);
      check("release_ready", bus.prodReady_out, 1);
      @(posedge clk);
      #1;
      bus.prodValid_in = 1'b0;
      @(negedge clk);
      check("release_consumed", bus.resValid_out, 0);
      @(posedge clk);
      #1;
      send_beat(6, 1'b0, 0, 0);
      send_beat(7, 1'b1, 0, 0);
      beats = {5, 6, 7};
      expect_window(beats, 0, 0);
      drain();

      // Back-to-back windows.
      stall_cycles = 0;
      r0 = n_results;
      for (int w = 0; w < 4; w++) begin
         beats = {};
         for (int j = 0; j < K; j++) beats.push_back(int'($urandom_range(0, 32767)) - 16384);
         send_window(beats, int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 10), 1'b0);
      end
      drain();
      check("b2b_stalls", stall_cycles, 0);
      check("b2b_results", n_results - r0, 4);

      // Randomized windows with random consumer stalls.
      rdy_mode = 2;
      for (int w = 0; w < 60; w++) begin
         int len;
         beats = {};
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : K;
         for (int j = 0; j < len; j++) beats.push_back(int'($urandom_range(0, 32767)) - 16384);
         send_window(beats, int'($urandom_range(0, 2097151)) - 1048576, $urandom_range(0, 14), 1'b1);
         if (w % 15 == 14) begin
            drain();
            pulse_clear();
            model_err = 1'b0;
            @(negedge clk);
            check("rand_clear_err", bus.lenErr_out, 0);
            @(posedge clk);
            #1;
         end
      end
      drain();
      rdy_mode = 0;
      @(posedge clk);
      #2;

      // Reset mid-window.
      beats = {5};
      send_window(beats, 0, 0, 1'b0);
      drain();
      check("pre_rst_err", bus.lenErr_out, 1);
      send_beat(1, 1'b0, 0, 0);
      send_beat(2, 1'b0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_err", bus.lenErr_out, 0);
      check("async_rst_ready", bus.prodReady_out, 1);
      check("async_rst_state", dbg_state, ST_ACCUM);
      model_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beats = {30, 40, 50};
      send_window(beats, 1, 1, 1'b0);
      drain();
      check("post_rst_err", bus.lenErr_out, 0);

      // Clear mid-window, with a competing last beat in the clear cycle.
      beats = {9};
      send_window(beats, 0, 0, 1'b0);
      drain();
      check("pre_clr_err", bus.lenErr_out, 1);
      send_beat(3, 1'b0, 0, 0);
      send_beat(4, 1'b0, 0, 0);
      clear = 1'b1;
      bus.prodValid_in = 1'b1;
      bus.prodLast_in  = 1'b1;
      bus.prodData_in  = 999;
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.prodValid_in = 1'b0;
      bus.prodLast_in  = 1'b0;
      model_err = 1'b0;
      @(negedge clk);
      check("clr_err", bus.lenErr_out, 0);
      check("clr_valid", bus.resValid_out, 0);
      @(posedge clk);
      #1;
      beats = {-20, 7, 100};
      send_window(beats, 3, 2, 1'b0);
      drain();
      check("post_clr_err", bus.lenErr_out, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_accum_quant.md
# conv_accum_quant

Accumulator/requantizer stage directly downstream of the `computeMult` 8×8 multiplier in the CNN datapath. It sums a stream of signed 32-bit products over one kernel window, adds a per-channel bias, and rounds and shifts the sum back to the 8-bit feature-map domain. The result is saturated to int8 and handed to the feature-map writer over a valid/ready handshake.

## Interface
- `KERNEL_LEN`, 25: products per window (5×5 kernel); used for length checking only.
- `ACC_W`, 32: accumulator width; must be ≥ 32.
- `clk_in` in 1: single clock, rising edge.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `clear_in` in 1: synchronous abort; drops the partial window and any held result.
- `prodValid_in` in 1: product beat valid.
- `prodLast_in` in 1: marks the final beat of the window.
- `prodData_in` in 32: signed product from `computeMult`.
- `prodReady_out` out 1: beat accepted when valid && ready.
- `bias_in` in 32: signed bias; sampled on the last beat.
- `shift_in` in 5: right-shift amount (0–31); sampled on the last beat.
- `resValid_out` out 1: result valid.
- `resData_out` out 8: signed int8 result.
- `resReady_in` in 1: consumer ready.
- `lenErr_out` out 1: sticky window-length error flag.

## Operation
- Two states:
  - ACCUM: collecting beats.
  - HOLD: result presented.
- The accumulator `acc` (ACC_W) and beat counter `cnt` (width clog2(KERNEL_LEN)+1) are cleared at the start of each window.
- Non-last beat accepted: `acc <= acc + prodData_in`; `cnt <= cnt + 1`.
- Last beat accepted:
  - `sum = acc + prodData_in + bias_in`, two's-complement wrap at ACC_W, no overflow flag.
  - Requantize `sum` into `resData_out`, set `resValid_out`, reset `acc` and `cnt` to 0, enter HOLD.
- Requantize steps:
  - Add round term `1 << (shift_in-1)` when `shift_in > 0`.
  - Arithmetic right shift by `shift_in`.
  - Optional ReLU (see Configuration).
  - Saturate to [-128, 127].
- Length check: on the last beat, if `cnt != KERNEL_LEN-1`, set `lenErr_out`. It stays set until reset or `clear_in`, and the result is still produced.
- `prodReady_out = !resValid_out || resReady_in`. A new window can start in the same cycle the held result is consumed.
- HOLD exits on `resValid_out && resReady_in`. Data stays stable while valid && !ready.
- `clear_in` has priority over all beats and handshakes in that cycle. It zeroes `acc`, `cnt`, `resValid_out` and `lenErr_out`, and returns to ACCUM.
- A window of exactly one beat (last on the first beat) is legal.

## Timing
- Reset values:
  - `resValid_out` = 0
  - `resData_out` = 0
  - `lenErr_out` = 0
  - `prodReady_out` = 1
  - state = ACCUM, `acc` = 0, `cnt` = 0
- Latency: `resValid_out` rises one cycle after the last beat is accepted.
- Throughput: one beat per cycle. There is no bubble between windows when `resReady_in` is held high.
- Reset asserted mid-window discards everything immediately, asynchronously.
- `prodReady_out` has a combinational path from `resReady_in`. The consumer must not derive `resReady_in` from `prodReady_out`.

## Configuration
- `CONV_ACC_RELU_EN` defined: negative shifted values are forced to 0 before saturation, so output range is [0, 127].
- `CONV_ACC_RELU_EN` undefined: no ReLU, so output range is [-128, 127].

## Structure
- Shared package `cnn_pkg` holds:
  - `ACC_W` default
  - int8 limits `Q_MAX = 127` and `Q_MIN = -128`
  - the state enum (`ST_ACCUM`, `ST_HOLD`)
- One sub-module, `acc_requant`: purely combinational round/shift/ReLU/saturate, taking the 32-bit sum and shift and producing int8.

## Test plan
- KERNEL_LEN=3; beats 100, 200, -50 (last on the 3rd); bias 6; shift 2 -> sum 256, (256+2)>>>2 = 64. `resData_out` = 64 one cycle later; `lenErr_out` = 0.
- Single beat 40000, last, bias 0, shift 8 -> (40000+128)>>>8 = 156, saturates to 127. `lenErr_out` = 1 when KERNEL_LEN≠1.
- Beat -1000, last, shift 2 -> (-998)>>>2 = -250. Result is -128 with the macro undefined, 0 with `CONV_ACC_RELU_EN`.
- Hold `resReady_in` low 5 cycles after a result:
  - `resValid_out` and data stay stable and `prodReady_out` = 0; the next window's first beat is not accepted.
  - Raising ready consumes the result and accepts that beat in the same cycle.
- Back-to-back windows with ready high -> one result per window and no idle cycles between them.
- Assert `rst_n_in` low after 2 beats, then send a full 3-beat window -> result reflects only the post-reset beats. Repeat using `clear_in` instead of reset; `lenErr_out` is cleared in both cases.
